// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time, buffers the word for decode.
// Optional feature macro: YSYX_22050612_IFU_EBREAK_STOP_EN (stop fetching after an ebreak is consumed).
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        halted
);

`ifdef YSYX_22050612_IFU_EBREAK_STOP_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3
    } state_t;
`endif

    state_t      state_r;
    logic [63:0] pc_r;
    logic [31:0] ibuf_r;
    logic        drop_r;
    logic [63:0] redirect_tgt_s;

    assign redirect_tgt_s = redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;

    // Fetch state machine, PC, instruction buffer and stale-response flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            ibuf_r  <= 32'h0000_0000;
            drop_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= S_REQ;
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_tgt_s;
                        if (req_ready) begin
                            // The old-address request is already out; its response must be dropped.
                            drop_r  <= 1'b1;
                            state_r <= S_WAIT;
                        end else begin
                            state_r <= S_REQ;
                        end
                    end else if (req_ready) begin
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_tgt_s;
                        if (resp_valid) begin
                            drop_r  <= 1'b0;
                            state_r <= S_REQ;
                        end else begin
                            drop_r  <= 1'b1;
                            state_r <= S_WAIT;
                        end
                    end else if (resp_valid) begin
                        if (drop_r) begin
                            drop_r  <= 1'b0;
                            state_r <= S_REQ;
                        end else begin
                            ibuf_r  <= resp_data;
                            state_r <= S_HOLD;
                        end
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_r    <= redirect_tgt_s;
                        state_r <= S_REQ;
                    end else if (inst_ready) begin
`ifdef YSYX_22050612_IFU_EBREAK_STOP_EN
                        if (ibuf_r == EBREAK) begin
                            state_r <= S_HALT;
                        end else begin
                            pc_r    <= pc_r + 64'd4;
                            state_r <= S_REQ;
                        end
`else
                        pc_r    <= pc_r + 64'd4;
                        state_r <= S_REQ;
`endif
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
`ifdef YSYX_22050612_IFU_EBREAK_STOP_EN
                S_HALT: begin
                    state_r <= S_HALT;
                end
`endif
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; inst_valid is masked by a live redirect.
    always_comb begin
        req_valid  = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;
        req_addr   = pc_r;
        inst_pc    = pc_r;
        inst       = ibuf_r;
        if (state_r == S_REQ) begin
            req_valid = 1'b1;
        end else begin
            req_valid = 1'b0;
        end
        if ((state_r == S_HOLD) && !redirect_valid) begin
            inst_valid = 1'b1;
        end else begin
            inst_valid = 1'b0;
        end
`ifdef YSYX_22050612_IFU_EBREAK_STOP_EN
        if (state_r == S_HALT) begin
            halted = 1'b1;
        end else begin
            halted = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed, table-driven bench for ysyx_22050612_ifu; one vector per clock cycle.
// Honours YSYX_22050612_IFU_EBREAK_STOP_EN for the ebreak sequence.
module tb_ysyx_22050612_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halted;

    int n_chk;
    int n_fail;

    ysyx_22050612_ifu #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic        rsp;
        logic [31:0] d;
        logic        ir;
        logic        rdv;
        logic [63:0] rpc;
        logic        e_rv;
        logic        e_iv;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rr, input logic rsp, input logic [31:0] d,
                                input logic ir, input logic rdv, input logic [63:0] rpc,
                                input logic e_rv, input logic e_iv, input logic [63:0] e_pc,
                                input logic [31:0] e_inst);
        vec_t v;
        v.rr = rr; v.rsp = rsp; v.d = d; v.ir = ir; v.rdv = rdv; v.rpc = rpc;
        v.e_rv = e_rv; v.e_iv = e_iv; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic rr, input logic rsp, input logic [31:0] d,
                         input logic ir, input logic rdv, input logic [63:0] rpc);
        @(negedge clk);
        req_ready = rr; resp_valid = rsp; resp_data = d;
        inst_ready = ir; redirect_valid = rdv; redirect_pc = rpc;
        #1;
    endtask

    task automatic chk_state(input string nm, input logic rv, input logic iv,
                             input logic [63:0] pc, input logic [31:0] ins, input logic hl);
        chk({nm, " req_valid"}, {63'd0, req_valid}, {63'd0, rv});
        chk({nm, " inst_valid"}, {63'd0, inst_valid}, {63'd0, iv});
        chk({nm, " req_addr"}, req_addr, pc);
        chk({nm, " inst_pc"}, inst_pc, pc);
        chk({nm, " halted"}, {63'd0, halted}, {63'd0, hl});
        if (iv) chk({nm, " inst"}, {32'd0, inst}, {32'd0, ins});
    endtask

    // Assert reset, check reset outputs, release, check the single IDLE cycle.
    task automatic do_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'd0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        #1;
        chk_state({nm, " in reset"}, 1'b0, 1'b0, RST_PC, 32'd0, 1'b0);
        chk({nm, " reset inst"}, {32'd0, inst}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_state({nm, " idle"}, 1'b0, 1'b0, RST_PC, 32'd0, 1'b0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'd0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;

        // Cycle-by-cycle vectors starting at the first REQ after reset.
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0000, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h00a0_0093, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_0000, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0000, 32'h00a0_0093));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0000, 32'h00a0_0093));
        tbl.push_back(mk(1'b1, 1'b1, 32'hdead_beef, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0000, 32'h00a0_0093));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0000, 32'h00a0_0093));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0000, 32'h00a0_0093));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0000, 32'h00a0_0093));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0004, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_0004, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0004, 32'h0000_0013));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0008, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_0008, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0008, 32'h0010_0093));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_000c, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_000c, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_000c, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0020_0113, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_000c, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_000c, 32'h0020_0113));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0010, 32'h0));
        // Redirect in WAIT, stale response two cycles later.
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 64'h8000_1002, 1'b0, 1'b0, 64'h8000_0010, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_1000, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hdead_beef, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_1000, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_1000, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_1000, 32'h0));
        // Redirect in the same cycle as a HOLD handshake.
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_0100, 1'b0, 1'b0, 64'h8000_1000, 32'h0));
        // Redirect in REQ with req_ready, then stale response.
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 64'h8000_0200, 1'b1, 1'b0, 64'h8000_0100, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hdead_beef, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_0200, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0200, 32'h0));
        // Redirect in WAIT coinciding with the response.
        tbl.push_back(mk(1'b0, 1'b1, 32'hdead_beef, 1'b1, 1'b1, 64'h8000_0300, 1'b0, 1'b0, 64'h8000_0200, 32'h0));
        // Redirect in REQ without req_ready; low address bits are cleared.
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 64'h8000_0407, 1'b1, 1'b0, 64'h8000_0300, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0404, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0010_0073, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h8000_0404, 32'h0));

        do_reset("rst0");
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rr, tbl[i].rsp, tbl[i].d, tbl[i].ir, tbl[i].rdv, tbl[i].rpc);
            chk_state($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_iv, tbl[i].e_pc, tbl[i].e_inst, 1'b0);
        end

        // ebreak sits in HOLD and is consumed.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        chk_state("ebreak hold", 1'b0, 1'b1, 64'h8000_0404, 32'h0010_0073, 1'b0);
`ifdef YSYX_22050612_IFU_EBREAK_STOP_EN
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h8000_0000);
        chk_state("halt0", 1'b0, 1'b0, 64'h8000_0404, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b1, 64'h8000_0800);
            chk_state($sformatf("halt%0d", k + 1), 1'b0, 1'b0, 64'h8000_0404, 32'h0, 1'b1);
        end
`else
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk_state("after ebreak", 1'b1, 1'b0, 64'h8000_0408, 32'h0, 1'b0);
        // PC increment wraps at 2^64.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 1'b1, 32'hdead_beef, 1'b0, 1'b0, 64'h0);
        chk_state("wrap stale", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk_state("wrap req", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        chk_state("wrap hold", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk_state("wrap next", 1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
`endif

        // Restart from reset, then a one-cycle reset pulse during WAIT.
        do_reset("rst1");
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk_state("restart req", 1'b1, 1'b0, RST_PC, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        chk_state("restart hold", 1'b0, 1'b1, RST_PC, 32'h0000_0013, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk_state("req2", 1'b1, 1'b0, 64'h8000_0004, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk_state("wait2", 1'b0, 1'b0, 64'h8000_0004, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_state("pulse", 1'b0, 1'b0, RST_PC, 32'h0, 1'b0);
        chk("pulse inst", {32'd0, inst}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_valid = 1'b1;
        resp_data = 32'hdead_beef;
        #1;
        chk_state("pulse idle", 1'b0, 1'b0, RST_PC, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'hdead_beef, 1'b1, 1'b0, 64'h0);
        chk_state("pulse req", 1'b1, 1'b0, RST_PC, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk_state("pulse req2", 1'b1, 1'b0, RST_PC, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0513, 1'b0, 1'b0, 64'h0);
        chk_state("pulse wait", 1'b0, 1'b0, RST_PC, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        chk_state("pulse hold", 1'b0, 1'b1, RST_PC, 32'h0000_0513, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_ifu

Instruction fetch unit for the ysyx_22050612 RV64 core, directly upstream of decode. It holds the PC and issues one word-aligned fetch request at a time over a valid/ready memory port. It buffers the returned 32-bit instruction and presents it with its PC to decode over a valid/ready handshake. It accepts PC redirects from execute (branches, jal/jalr) at any point, discarding any in-flight or buffered instruction.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  64  fetch address; always equals the current PC, bits [1:0] = 0.
- resp_valid  in  1  fetch data valid; one response per accepted request, in order.
- resp_data  in  32  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  buffered instruction.
- inst_pc  out  64  PC of `inst`.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  64  redirect target; bits [1:0] ignored and forced to 0.
- halted  out  1  fetch stopped on ebreak; only driven high when the configuration macro is defined.

## Operation
- State machine states: IDLE, REQ, WAIT, HOLD, and HALT (HALT exists only with the macro).
- Registers:
  - pc[63:0]
  - ibuf[31:0]
  - drop (1 bit): the outstanding response is stale.
- IDLE: entered only from reset. Moves to REQ on the next cycle.
- REQ: req_valid=1. On req_ready, moves to WAIT.
- WAIT: waits for resp_valid.
  - If drop=1: discard the response, clear drop, move to REQ.
  - Otherwise: ibuf<=resp_data, move to HOLD.
- HOLD: inst_valid=1, inst=ibuf, inst_pc=pc.
  - On handshake: pc<=pc+4 (modulo 2^64, wrapping), move to REQ.
- Redirect has the highest priority. In every state except IDLE and HALT it sets pc<=redirect_pc with bits [1:0] cleared, and then:
  - REQ, no req_ready: stay in REQ.
  - REQ, with req_ready in the same cycle: the request counts as issued; set drop=1 and move to WAIT.
  - WAIT, no resp_valid: set drop=1 and stay in WAIT.
  - WAIT, with resp_valid in the same cycle: discard the response, drop=0, move to REQ.
  - HOLD: discard ibuf and move to REQ. inst_valid is masked to 0 combinationally while redirect_valid=1, so decode never accepts the stale instruction.
- A redirect in the same cycle as a HOLD handshake wins. There is no pc+4 and no handshake that cycle.

## Timing
- Reset values (asserted rst_n=0): state=IDLE, pc=RESET_PC, drop=0, ibuf=0.
  - Outputs during reset: req_valid=0, inst_valid=0, inst=0, inst_pc=RESET_PC, halted=0.
- First req_valid is in the second rising edge's cycle after rst_n deasserts. That is, IDLE lasts one cycle.
- Minimum throughput: REQ (1) + WAIT (≥1) + HOLD (≥1) = 3 cycles per instruction with zero-wait memory and an always-ready decode.
- resp_valid may arrive as early as the cycle after acceptance. resp_valid outside WAIT is ignored.
- req_addr and inst_pc are registered and stable while the corresponding valid is high and not accepted.
- Reset asserted mid-operation: immediate return to the reset values. Any in-flight memory response after reset is ignored, because the state is IDLE/REQ and not WAIT.

## Configuration
- YSYX_22050612_IFU_EBREAK_STOP_EN defined:
  - When the HOLD handshake completes with inst==32'h00100073, the unit moves to HALT instead of REQ, and pc is not incremented.
  - In HALT: req_valid=0, inst_valid=0, halted=1. Redirects are ignored. Only reset exits HALT.
- Macro undefined:
  - No HALT state; halted is tied to 0.
  - ebreak is fetched and passed on like any other instruction.

## Test plan
- Reset, then memory always ready with a 1-cycle response, decode always ready. Expect:
  - req_addr 0x80000000, 0x80000004, 0x80000008 on successive requests.
  - inst_pc matches each request.
  - One instruction every 3 cycles.
- Decode holds inst_ready=0 for 5 cycles in HOLD with resp 0x00a00093 at PC 0x80000000. Expect:
  - inst_valid, inst and inst_pc stable for the whole stall.
  - No new request issued.
  - After the handshake, req_addr=0x80000004.
- Redirect to 0x80001002 while in WAIT, response 0xdeadbeef arrives 2 cycles later. Expect:
  - Response discarded; inst_valid never high with 0xdeadbeef.
  - Next req_addr=0x80001000.
- Redirect to 0x80000100 in the same cycle as a HOLD handshake. Expect:
  - inst_valid=0 that cycle.
  - Next req_addr=0x80000100, not 0x80000004.
- With the macro defined, fetch returns 0x00100073 at 0x80000010 and is accepted. Expect:
  - halted=1 and req_valid=0 permanently.
  - A redirect is ignored.
  - Deasserting reset restarts fetch at 0x80000000.
- rst_n pulsed low for 1 cycle during WAIT. Expect:
  - Outputs at their reset values at once.
  - A late resp_valid is ignored.
  - The first request is 0x80000000 after the IDLE cycle.
